regfile_nport: RTL

Parametrised multi-port register file for the LEGv8 datapath, generalising the fixed 32×64-bit, single-read 32:1 selection tree into a configurable-width, configurable-depth storage array. It provides one write port, NREAD independent synchronous read ports, and write-to-read bypass. A hardwired zero register (XZR) is optional. It sits between decode, which supplies the read addresses, and writeback, which supplies the write port.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_read_port.sv | 65 ++++++
 rtl/regfile_nport.sv | 59 +++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared sizing helpers and types for the LEGv8 multi-port register file.
package regfile_pkg;

   localparam int DEF_WIDTH = 64;
   localparam int DEF_DEPTH = 32;

   typedef logic [DEF_WIDTH-1:0] rf_word_t;

   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction

   // The hardwired zero register always sits at the top index.
   function automatic int xzr_idx(input int depth);
      return depth - 1;
   endfunction

   localparam int XZR_IDX = xzr_idx(DEF_DEPTH);

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: binary select tree, write-first bypass, zero rule.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int WIDTH    = 64,
   parameter int DEPTH    = 32,
   parameter int ZERO_REG = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       rd_en,
   input  logic [addr_w(DEPTH)-1:0]   rd_addr,
   input  logic                       wr_en,
   input  logic [addr_w(DEPTH)-1:0]   wr_addr,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic [WIDTH-1:0]           regs [DEPTH],
   output logic [WIDTH-1:0]           rd_data,
   output logic                       rd_valid
);

   localparam int AW = addr_w(DEPTH);
   localparam logic [AW-1:0] XZR = AW'(xzr_idx(DEPTH));

   logic [WIDTH-1:0] tree_out;
   logic [WIDTH-1:0] sel;

   // Level k halves the candidates using address bit k; level 0 touches the array.
   for (genvar k = 0; k < AW; k++) begin : g_lvl
      localparam int N = DEPTH >> (k + 1);
      logic [WIDTH-1:0] node [N];
      for (genvar j = 0; j < N; j++) begin : g_mux
         if (k == 0) begin : g_leaf
            assign node[j] = rd_addr[k] ? regs[2*j+1] : regs[2*j];
         end else begin : g_inner
            assign node[j] = rd_addr[k] ? g_lvl[k-1].node[2*j+1] : g_lvl[k-1].node[2*j];
         end
      end
   end

   assign tree_out = g_lvl[AW-1].node[0];

   // Zero rule outranks bypass, which outranks the stored value.
   always_comb begin
      sel = tree_out;
      if (wr_en && (wr_addr == rd_addr)) begin
         sel = wr_data;
      end
      if ((ZERO_REG != 0) && (rd_addr == XZR)) begin
         sel = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_data <= sel;
         end
      end
   end

endmodule

// File: rtl/regfile_nport.sv
// Parametrised register file: flop array, single write port, NREAD read ports.
module regfile_nport
   import regfile_pkg::*;
#(
   parameter int WIDTH    = 64,
   parameter int DEPTH    = 32,
   parameter int NREAD    = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [addr_w(DEPTH)-1:0]   wr_addr,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic [NREAD-1:0]           rd_en,
   input  logic [addr_w(DEPTH)-1:0]   rd_addr  [NREAD],
   output logic [WIDTH-1:0]           rd_data  [NREAD],
   output logic [NREAD-1:0]           rd_valid
);

   localparam int AW = addr_w(DEPTH);
   localparam logic [AW-1:0] XZR = AW'(xzr_idx(DEPTH));

   logic [WIDTH-1:0] regs [DEPTH];
   logic             wr_ok;

   // Writes aimed at the zero register are dropped so it can never hold data.
   assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == XZR));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_ok) begin
         regs[wr_addr] <= wr_data;
      end
   end

   for (genvar p = 0; p < NREAD; p++) begin : g_port
      regfile_read_port #(
         .WIDTH    (WIDTH),
         .DEPTH    (DEPTH),
         .ZERO_REG (ZERO_REG)
      ) u_port (
         .clk      (clk),
         .rst_n    (rst_n),
         .rd_en    (rd_en[p]),
         .rd_addr  (rd_addr[p]),
         .wr_en    (wr_en),
         .wr_addr  (wr_addr),
         .wr_data  (wr_data),
         .regs     (regs),
         .rd_data  (rd_data[p]),
         .rd_valid (rd_valid[p])
      );
   end

endmodule
